// File: rtl/ifft8_pkg.sv
// Shared types, twiddle table and single-precision add/multiply cells for the 8-point inverse FFT.
package ifft8_pkg;

  localparam int unsigned FLOAT_W = 32;
  localparam logic [31:0] FLOAT_ONE  = 32'h3F800000;
  localparam logic [31:0] FLOAT_ZERO = 32'h00000000;
  localparam logic [31:0] FLOAT_QNAN = 32'h7FC00000;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } cplx_t;

  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

  // W = e^{+j*2*pi*t/8}
  localparam cplx_t TWIDDLE_INV [4] = '{
    cplx_t'{FLOAT_ONE,    FLOAT_ZERO},
    cplx_t'{32'h3F3504F3, 32'h3F3504F3},
    cplx_t'{FLOAT_ZERO,   FLOAT_ONE},
    cplx_t'{32'hBF3504F3, 32'h3F3504F3}
  };

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  function automatic logic [31:0] fp_neg(input logic [31:0] a);
    return {~a[31], a[30:0]};
  endfunction

  // Round-to-nearest-even multiply; denormal operands and results flush to signed zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [24:0] m;
    logic        g, st;
    int          e;
    s = a[31] ^ b[31];
    if ((a[30:23] == 8'hFF && a[22:0] != 23'h0) || (b[30:23] == 8'hFF && b[22:0] != 23'h0))
      return FLOAT_QNAN;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
      return (a[30:23] == 8'h00 || b[30:23] == 8'h00) ? FLOAT_QNAN : {s, 8'hFF, 23'h0};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = {1'b0, p[47:24]}; g = p[23]; st = |p[22:0]; e = e + 1;
    end else begin
      m = {1'b0, p[46:23]}; g = p[22]; st = |p[21:0];
    end
    if (g && (st || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1; e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), 23'(m)};
  endfunction

  // Round-to-nearest-even add with guard/round/sticky; exact cancellation gives +0.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [26:0] mx, my, mask;
    logic [27:0] m;
    logic [24:0] r;
    int          e, d;
    if ((a[30:23] == 8'hFF && a[22:0] != 23'h0) || (b[30:23] == 8'hFF && b[22:0] != 23'h0))
      return FLOAT_QNAN;
    if (a[30:23] == 8'hFF) return (b[30:23] == 8'hFF && a[31] != b[31]) ? FLOAT_QNAN : a;
    if (b[30:23] == 8'hFF) return b;
    if (a[30:23] == 8'h00 && b[30:23] == 8'h00) return {a[31] & b[31], 31'h0};
    if (a[30:23] == 8'h00) return b;
    if (b[30:23] == 8'h00) return a;
    if (a[30:0] >= b[30:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    d  = int'(x[30:23]) - int'(y[30:23]);
    e  = int'(x[30:23]);
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    if (d > 26) my = 27'd1;
    else begin
      mask = (27'd1 << d) - 27'd1;
      my   = (my >> d) | 27'(|(my & mask));
    end
    if (x[31] == y[31]) begin
      m = 28'(mx) + 28'(my);
      if (m[27]) begin
        m = (m >> 1) | 28'(m[0]); e = e + 1;
      end
    end else begin
      m = 28'(mx) - 28'(my);
      if (m == 28'h0) return FLOAT_ZERO;
      for (int i = 0; i < 26; i++) begin
        if (!m[26]) begin
          m = m << 1; e = e - 1;
        end
      end
    end
    r = 25'(m[26:3]) + 25'(m[2] && (m[1] || m[0] || m[3]));
    if (r[24]) begin
      r = r >> 1; e = e + 1;
    end
    if (e >= 255) return {x[31], 8'hFF, 23'h0};
    if (e <= 0) return {x[31], 31'h0};
    return {x[31], 8'(e), 23'(r)};
  endfunction

endpackage

// File: rtl/ifft8_butterfly.sv
// Combinational radix-2 DIT butterfly: a_new = a + w*b, b_new = a - w*b.
module ifft8_butterfly
  import ifft8_pkg::*;
(
  input  cplx_t a,
  input  cplx_t b,
  input  cplx_t w,
  output cplx_t a_new,
  output cplx_t b_new
);

  logic [31:0] wr_br, wi_bi, wr_bi, wi_br;
  cplx_t       wb;

  always_comb begin
    wr_br       = fp_mul(w.re, b.re);
    wi_bi       = fp_mul(w.im, b.im);
    wr_bi       = fp_mul(w.re, b.im);
    wi_br       = fp_mul(w.im, b.re);
    wb.re       = fp_add(wr_br, fp_neg(wi_bi));
    wb.im       = fp_add(wr_bi, wi_br);
    a_new.re    = fp_add(a.re, wb.re);
    a_new.im    = fp_add(a.im, wb.im);
    b_new.re    = fp_add(a.re, fp_neg(wb.re));
    b_new.im    = fp_add(a.im, fp_neg(wb.im));
  end

endmodule

// File: rtl/ifft8_stream.sv
// Streaming 8-point inverse FFT: load 8 bins, 12 in-place butterflies, drain 8 real samples.
// Define IFFT8_SCALE_EN to scale outputs by 1/8; otherwise raw sums are emitted.
module ifft8_stream
  import ifft8_pkg::*;
#(
  parameter int unsigned N_PTS = 8,
  parameter int unsigned FW    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*FW-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FW-1:0]   out_data,
  output logic            out_last,
  output logic            busy
);

  if (N_PTS != 8 || FW != FLOAT_W) begin : g_cfg_check
    $error("ifft8_stream supports only N_PTS=8 and FW=32");
  end

  state_t      state;
  logic [2:0]  ld_cnt, drn_idx;
  logic [1:0]  stage, bfly;
  cplx_t       buffer [8];
  logic [2:0]  span, pa, pb;
  logic [1:0]  tw;
  cplx_t       bf_a, bf_b;
  logic        load_fire;

`ifdef IFFT8_SCALE_EN
  function automatic logic [31:0] out_val(input logic [31:0] re);
    if (re[30:23] > 8'd3) return {re[31], re[30:23] - 8'd3, re[22:0]};
    return {re[31], 31'h0};
  endfunction
`else
  function automatic logic [31:0] out_val(input logic [31:0] re);
    return re;
  endfunction
`endif

  assign load_fire = (state == LOAD) && in_valid && in_ready;

  // Butterfly pair and twiddle index for the current stage/butterfly
  always_comb begin
    span = 3'd1 << stage;
    pa   = ((3'(bfly) >> stage) << (stage + 2'd1)) | (3'(bfly) & (span - 3'd1));
    pb   = pa + span;
    tw   = 2'((3'(bfly) & (span - 3'd1)) << (3'd2 - 3'(stage)));
  end

  ifft8_butterfly u_bfly (
    .a     (buffer[pa]),
    .b     (buffer[pb]),
    .w     (TWIDDLE_INV[tw]),
    .a_new (bf_a),
    .b_new (bf_b)
  );

  // Working buffer: bit-reversed load, in-place butterfly update
  always_ff @(posedge clk) begin
    if (load_fire) begin
      buffer[bitrev3(ld_cnt)] <= cplx_t'(in_data);
    end else if (state == COMPUTE) begin
      buffer[pa] <= bf_a;
      buffer[pb] <= bf_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      ld_cnt    <= 3'd0;
      drn_idx   <= 3'd0;
      stage     <= 2'd0;
      bfly      <= 2'd0;
    end else begin
      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (load_fire) begin
            ld_cnt <= ld_cnt + 3'd1;
            if (ld_cnt == 3'd7) begin
              state    <= COMPUTE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          bfly <= bfly + 2'd1;
          if (bfly == 2'd3) begin
            stage <= stage + 2'd1;
            if (stage == 2'd2) begin
              stage <= 2'd0;
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // First DRAIN cycle presents x[0]; afterwards advance on each accepted sample
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= out_val(buffer[0].re);
            out_last  <= 1'b0;
            drn_idx   <= 3'd0;
          end else if (out_ready) begin
            if (drn_idx == 3'd7) begin
              state     <= LOAD;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              drn_idx  <= drn_idx + 3'd1;
              out_data <= out_val(buffer[drn_idx + 3'd1].re);
              out_last <= (drn_idx == 3'd6);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ifft8_stream.sv
// Scoreboard bench for ifft8_stream: directed single-bin/flat frames, backpressure, mid-frame reset.
module tb_ifft8_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  always #5 clk = ~clk;

  ifft8_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

`ifdef IFFT8_SCALE_EN
  localparam logic [31:0] P8 = 32'h3F800000, N8 = 32'hBF800000;
  localparam logic [31:0] PR = 32'h3F3504F3, NR = 32'hBF3504F3;
`else
  localparam logic [31:0] P8 = 32'h41000000, N8 = 32'hC1000000;
  localparam logic [31:0] PR = 32'h40B504F3, NR = 32'hC0B504F3;
`endif
  localparam logic [31:0] Z = 32'h0;
  localparam logic [31:0] EIGHT = 32'h41000000;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          hs_cyc = 0;
  bit          lat_armed = 0;
  bit          bp_mode = 0;
  int          bp_phase = 0;
  int          out_idx = 0;
  bit          held = 0;
  bit          prev_valid = 0;
  logic [31:0] held_data;
  logic [31:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (!(act === exp || (exp === 32'h0 && act[30:0] === 31'h0))) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Downstream ready: always 1, or the 1,0,0 pattern while backpressure is on
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      out_ready = (bp_phase % 3 == 0);
      bp_phase++;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each accepted output sample
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      prev_valid = 0;
      held       = 0;
      out_idx    = 0;
    end else begin
      if (held) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", out_data, held_data);
        held = 0;
      end
      if (out_valid && !prev_valid && lat_armed) begin
        check("latency", 32'(cyc - hs_cyc), 32'd13);
        lat_armed = 0;
      end
      if (out_valid) begin
        check("in_ready_low", 32'(in_ready), 32'd0);
        check("busy_high", 32'(busy), 32'd1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got %08h with empty scoreboard", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e);
          check("out_last", 32'(out_last), 32'(out_idx == 7));
          out_idx = (out_idx + 1) % 8;
        end
      end else if (out_valid) begin
        held      = 1;
        held_data = out_data;
      end
      prev_valid = out_valid;
    end
  end

  task automatic send_frame(input logic [63:0] x [8], input logic [31:0] e [8], input bit push);
    int k = 0;
    int guard = 0;
    while (k < 8 && guard < 300) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = x[k];
      if (in_ready) begin
        k++;
        if (k == 8) begin
          hs_cyc = cyc + 1;
          if (push) begin
            for (int i = 0; i < 8; i++) exp_q.push_back(e[i]);
            lat_armed = 1;
          end
        end
      end
      guard++;
    end
    check("load_accepted", 32'(k), 32'd8);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
  endtask

  logic [63:0] x_v [8];
  logic [31:0] e_v [8];

  function automatic void one_bin(input int k, input logic [63:0] val);
    for (int i = 0; i < 8; i++) x_v[i] = (i == k) ? val : 64'h0;
  endfunction

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // DC bin
    one_bin(0, {EIGHT, 32'h0});
    e_v = '{P8, P8, P8, P8, P8, P8, P8, P8};
    send_frame(x_v, e_v, 1);
    wait_done();

    // Flat spectrum
    for (int i = 0; i < 8; i++) x_v[i] = {32'h3F800000, 32'h0};
    e_v = '{P8, Z, Z, Z, Z, Z, Z, Z};
    send_frame(x_v, e_v, 1);
    wait_done();

    // Nyquist bin
    one_bin(4, {EIGHT, 32'h0});
    e_v = '{P8, N8, P8, N8, P8, N8, P8, N8};
    send_frame(x_v, e_v, 1);
    wait_done();

    // Real bin 1 under backpressure: 8*cos(pi*n/4)
    bp_mode  = 1;
    bp_phase = 0;
    one_bin(1, {EIGHT, 32'h0});
    e_v = '{P8, PR, Z, NR, N8, NR, Z, PR};
    send_frame(x_v, e_v, 1);
    wait_done();
    bp_mode = 0;

    // Imaginary bin 1: -8*sin(pi*n/4)
    one_bin(1, {32'h0, EIGHT});
    e_v = '{Z, NR, N8, NR, Z, PR, P8, PR};
    send_frame(x_v, e_v, 1);
    wait_done();

    // Reset during butterfly cycle 5 discards the frame
    one_bin(0, {EIGHT, 32'h0});
    send_frame(x_v, e_v, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready_back", 32'(in_ready), 32'd1);
    e_v = '{P8, P8, P8, P8, P8, P8, P8, P8};
    send_frame(x_v, e_v, 1);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ifft8_stream.md
Name: ifft8_stream

Overview:
- Sequential 8-point inverse FFT, radix-2 decimation-in-time, IEEE-754 single precision.
- Consumes 8 complex spectrum words {re[63:32], im[31:0]}, one per handshake, in natural order X[0]..X[7].
- Emits 8 real time-domain samples x[0]..x[7] as 32-bit floats.
- Return path for the forward 8-point FFT. Shares the same {re,im} 64-bit packing, so forward output feeds this input directly.

Parameters:
- N_PTS, 8, transform size; fixed at 8 (only supported value, guarded by elaboration check).
- FW, 32, float word width; complex word = 2*FW.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts input word this cycle.
- in_data  in  64  complex spectrum sample {re,im}.
- out_valid  out  1  output sample present.
- out_ready  in  1  downstream accepts output.
- out_data  out  32  real time-domain sample.
- out_last  out  1  high with x[7].
- busy  out  1  high in COMPUTE or DRAIN.

Behaviour:
- Reset, synchronous, evaluated at clk rising edge: in_ready=0 during the rst cycle, then 1; out_valid=0, out_data=0, out_last=0, busy=0, all counters=0, state=LOAD. Buffer contents are don't-care.
- Storage: 8 x 64-bit working buffer, registers.
- Input word k is written at address bitrev3(k), e.g. k=1 goes to address 4 and k=3 goes to address 6.
- LOAD:
  - in_ready=1.
  - A transfer occurs when in_valid&&in_ready.
  - Load counter increments 0..7. On the 8th transfer, go to COMPUTE and drop in_ready the next cycle.
- COMPUTE: 3 stages x 4 butterflies = 12 cycles, one butterfly per cycle.
  - Stage s in 0..2; span = 1<<s.
  - Butterfly index b in 0..3 selects pair (p, p+span), where p = ((b>>s)<<(s+1)) | (b & (span-1)).
  - Twiddle index t = (b & (span-1)) << (2-s).
  - Butterfly writes A'=A+W*B and B'=A-W*B back in place at the end of the same cycle.
  - Inverse twiddles W=e^{+j2*pi*t/8}, as constant {re,im}:
    - t0 = {3F800000, 00000000}
    - t1 = {3F3504F3, 3F3504F3}
    - t2 = {00000000, 3F800000}
    - t3 = {BF3504F3, 3F3504F3}
  - After stage 2 b=3, go to DRAIN.
- DRAIN:
  - out_valid=1, out_data = scaled real part of buffer[i] for i=0..7, natural order.
  - Hold out_data stable while out_valid&&!out_ready.
  - Advance i on out_valid&&out_ready.
  - out_last=1 when i=7.
  - After the i=7 transfer: go to LOAD, out_valid=0 the next cycle.
  - The imaginary parts are discarded; they are ~0 for Hermitian input.
- Latency: first out_valid 13 cycles after the 8th input transfer (1 transition cycle + 12 butterfly cycles). Minimum frame period 8+1+12+8=29 cycles.
- busy=1 in COMPUTE and DRAIN.
- No overlap: input is not accepted in COMPUTE or DRAIN.
- Arithmetic:
  - Add/multiply use the team's single-precision add and multiply cells, round-to-nearest-even.
  - Denormals are flushed to zero; NaN/Inf propagate per the cell rules.
- Scaling by 1/8 (see Optional Feature):
  - If exponent field > 3: subtract 3 from the exponent.
  - If exponent field <= 3: output signed zero.
  - 0x00000000 and 0x80000000 pass unchanged.
- rst during any state aborts the frame immediately and returns to the reset values. The partial frame is lost.
- in_valid while in_ready=0 is ignored and has no effect.

Optional Feature:
- Macro IFFT8_SCALE_EN.
  - Defined: outputs scaled by 1/8 as above (true inverse).
  - Undefined: the scaler is removed and out_data = raw real part, i.e. the sum (8x the true inverse).
- Latency is identical in both builds.

Decomposition:
- Package ifft8_pkg:
  - typedef cplx_t = struct {logic[31:0] re, im}
  - state enum {LOAD, COMPUTE, DRAIN}
  - TWIDDLE_INV[0:3] constant table
  - bitrev3 function
  - FLOAT_ONE/FLOAT_ZERO constants
- Sub-module ifft8_butterfly, purely combinational:
  - Inputs: A, B, W.
  - Outputs: A', B'.
  - Built from 4 multipliers and 6 adders.
- The top holds the FSM, counters, buffer, address generation and the scaler.

Test Plan:
- DC bin: X[0]={41000000,0}, others 0 -> scaled build: all 8 outputs 3F800000; out_last on the 8th output only.
- Flat spectrum: all X[k]={3F800000,0} -> x[0]=3F800000, x[1..7]=00000000 (±0 accepted).
- Nyquist bin: X[4]={41000000,0}, others 0 -> outputs alternate 3F800000, BF800000 starting at x[0].
- Backpressure: out_ready toggling 1,0,0,1... -> out_data held while stalled, exactly 8 transfers, in_ready=0 until the last transfer completes.
- Reset mid-COMPUTE: assert rst at butterfly cycle 5 -> next cycle out_valid=0, busy=0; after deassert, a clean DC frame yields 8x 3F800000.
- Unscaled build (IFFT8_SCALE_EN undefined): DC frame -> all outputs 41000000; first out_valid exactly 13 cycles after the 8th input handshake.
